// File: rtl/nas_pkt_loader_if.sv
// Bus bundle between the NAS packet loader and its surroundings: byte stream in,
// packet SRAM write port, detector start handshake, result SRAM read port and result record.
interface nas_pkt_loader_if;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic        pkt_sram_we;
  logic [15:0] pkt_sram_addr;
  logic [7:0]  pkt_sram_wdata;
  logic        ids_valid;
  logic        ids_ready;
  logic [15:0] res_sram_addr;
  logic [31:0] res_sram_rdata;
  logic        result_valid;
  logic        result_ready;
  logic [5:0]  result_code;
  logic [15:0] result_len;
  logic        err_overflow;
  logic        err_timeout;

  // Loader side.
  modport slave (
    input  s_valid, s_data, s_last, ids_ready, res_sram_rdata, result_ready,
    output s_ready, pkt_sram_we, pkt_sram_addr, pkt_sram_wdata, ids_valid,
    res_sram_addr, result_valid, result_code, result_len, err_overflow, err_timeout
  );

  // Environment side (packet source, SRAMs, detector, result consumer).
  modport master (
    output s_valid, s_data, s_last, ids_ready, res_sram_rdata, result_ready,
    input  s_ready, pkt_sram_we, pkt_sram_addr, pkt_sram_wdata, ids_valid,
    res_sram_addr, result_valid, result_code, result_len, err_overflow, err_timeout
  );
endinterface

// File: rtl/nas_pkt_loader.sv
// Loads one NAS message into packet SRAM (length at addr 0, payload at 1..N), starts the
// intrusion detector, then reads its result word at N+1 and reports the 6-bit attack code.
module nas_pkt_loader #(
  parameter int MAX_LEN        = 255,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic             clk,
  input logic             reset_n,
  nas_pkt_loader_if.slave bus
);

  localparam int               TMO_W     = $clog2(TIMEOUT_CYCLES);
  localparam logic [15:0]      MAX_LEN_W = 16'(MAX_LEN);
  localparam logic [15:0]      OVF_LEN   = 16'(MAX_LEN + 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_DROP, S_HDR, S_KICK,
    S_WAIT_BUSY, S_WAIT_DONE, S_READ, S_CAPTURE, S_REPORT
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [15:0]      len_q, len_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [5:0]       code_q, code_d;
  logic             ovf_q, ovf_d;
  logic             terr_q, terr_d;
  logic [15:0]      raddr_q, raddr_d;

  logic             s_ready_c;
  logic             we_c;
  logic [15:0]      waddr_c;
  logic [7:0]       wdata_c;
  logic             ids_valid_c;
  logic             tmo_hit;
  logic             unused_rdata;

  assign tmo_hit      = (tmo_q == TMO_LAST);
  assign unused_rdata = ^bus.res_sram_rdata[31:6];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      tmo_q   <= '0;
      code_q  <= '0;
      ovf_q   <= 1'b0;
      terr_q  <= 1'b0;
      raddr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      tmo_q   <= tmo_d;
      code_q  <= code_d;
      ovf_q   <= ovf_d;
      terr_q  <= terr_d;
      raddr_q <= raddr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    tmo_d       = tmo_q;
    code_d      = code_q;
    ovf_d       = ovf_q;
    terr_d      = terr_q;
    raddr_d     = raddr_q;
    s_ready_c   = 1'b0;
    we_c        = 1'b0;
    waddr_c     = '0;
    wdata_c     = '0;
    ids_valid_c = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.s_valid) state_d = S_LOAD;
      end
      S_LOAD: begin
        s_ready_c = 1'b1;
        if (bus.s_valid) begin
          // The byte after MAX_LEN is never written; the packet is only drained.
          if (cnt_q == MAX_LEN_W) begin
            if (bus.s_last) begin
              state_d = S_REPORT;
              ovf_d   = 1'b1;
              code_d  = '0;
              len_d   = OVF_LEN;
            end else begin
              state_d = S_DROP;
            end
          end else begin
            we_c    = 1'b1;
            waddr_c = cnt_q + 16'd1;
            wdata_c = bus.s_data;
            cnt_d   = cnt_q + 16'd1;
            if (bus.s_last) begin
              len_d   = cnt_q + 16'd1;
              state_d = S_HDR;
            end
          end
        end
      end
      S_DROP: begin
        s_ready_c = 1'b1;
        if (bus.s_valid && bus.s_last) begin
          state_d = S_REPORT;
          ovf_d   = 1'b1;
          code_d  = '0;
          len_d   = OVF_LEN;
        end
      end
      S_HDR: begin
        we_c    = 1'b1;
        wdata_c = len_q[7:0];
        state_d = S_KICK;
      end
      S_KICK: begin
        if (bus.ids_ready) begin
          ids_valid_c = 1'b1;
          tmo_d       = TMO_ONE;
          state_d     = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (tmo_hit) begin
          state_d = S_REPORT;
          terr_d  = 1'b1;
          code_d  = '0;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
          if (!bus.ids_ready) state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        // A completion seen in the last allowed cycle still wins over the timeout.
        if (bus.ids_ready) begin
          state_d = S_READ;
          raddr_d = len_q + 16'd1;
        end else if (tmo_hit) begin
          state_d = S_REPORT;
          terr_d  = 1'b1;
          code_d  = '0;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      S_READ: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        code_d  = bus.res_sram_rdata[5:0];
        state_d = S_REPORT;
      end
      S_REPORT: begin
        if (bus.result_ready) begin
          state_d = S_IDLE;
          ovf_d   = 1'b0;
          terr_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Combinational strobes are masked by reset so the detector start drops immediately.
  assign bus.s_ready        = s_ready_c & reset_n;
  assign bus.pkt_sram_we    = we_c & reset_n;
  assign bus.pkt_sram_addr  = waddr_c;
  assign bus.pkt_sram_wdata = wdata_c;
  assign bus.ids_valid      = ids_valid_c & reset_n;
  assign bus.res_sram_addr  = raddr_q;
  assign bus.result_valid   = (state_q == S_REPORT) & reset_n;
  assign bus.result_code    = code_q;
  assign bus.result_len     = len_q;
  assign bus.err_overflow   = ovf_q;
  assign bus.err_timeout    = terr_q;

endmodule
